spgd_dither_sequencer: RTL and testbench

- Upstream stage of the dither DAC driver: generates the dither pulse P that selects which DAC channel carries the high perturbation value.
- Sequences each SPGD perturbation pair: a P-high half, then a P-low half.
- Issues a one-cycle sample strobe after a programmable settle time in each half, so the metric ADC path captures J+ and J-.
- Counts completed pairs for the SPGD update logic.

---
 rtl/spgd_pkg.sv | 13 +
 rtl/spgd_cfg_shadow.sv | 54 +++++
 rtl/spgd_dither_sequencer.sv | 129 ++++++++++++
 tb/tb_spgd_dither_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD dither sequencer: FSM state encoding and
// the minimum legal half period.
package spgd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int unsigned MIN_HALF_PERIOD = 2;

endpackage

// File: rtl/spgd_cfg_shadow.sv
// Shadow registers for the half period and settle time, clamped on load so the
// sequencer always sees N >= 2 and S <= N-1.
module spgd_cfg_shadow
  import spgd_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] half_period,
  input  logic [CNT_WIDTH-1:0] settle_cycles,
  output logic [CNT_WIDTH-1:0] n_clamp,
  output logic [CNT_WIDTH-1:0] s_clamp,
  output logic [CNT_WIDTH-1:0] eff_n,
  output logic [CNT_WIDTH-1:0] eff_s
);

  localparam logic [CNT_WIDTH-1:0] NMIN = CNT_WIDTH'(MIN_HALF_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] eff_n_q, eff_n_d;
  logic [CNT_WIDTH-1:0] eff_s_q, eff_s_d;

  // Clamped view of the live inputs; the top uses it on the load cycle so
  // its registered outputs line up with the values being latched.
  always_comb begin
    n_clamp = (half_period < NMIN) ? NMIN : half_period;
    s_clamp = (settle_cycles > (n_clamp - ONE)) ? (n_clamp - ONE) : settle_cycles;
  end

  always_comb begin
    eff_n_d = eff_n_q;
    eff_s_d = eff_s_q;
    if (load) begin
      eff_n_d = n_clamp;
      eff_s_d = s_clamp;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eff_n_q <= NMIN;
      eff_s_q <= '0;
    end else begin
      eff_n_q <= eff_n_d;
      eff_s_q <= eff_s_d;
    end
  end

  assign eff_n = eff_n_q;
  assign eff_s = eff_s_q;

endmodule

// File: rtl/spgd_dither_sequencer.sv
// Dither pulse sequencer: P-high half then P-low half per perturbation pair,
// a sample strobe at the settle point of each half, and a completed-pair count.
module spgd_dither_sequencer
  import spgd_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned PAIR_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic [CNT_WIDTH-1:0]      half_period,
  input  logic [CNT_WIDTH-1:0]      settle_cycles,
  output logic                      P,
  output logic                      sample_strobe,
  output logic                      sample_phase,
  output logic                      pair_done,
  output logic                      busy,
  output logic [PAIR_CNT_WIDTH-1:0] pair_count
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [PAIR_CNT_WIDTH-1:0] pair_count_q, pair_count_d;
  logic                      p_q, p_d;
  logic                      strobe_q, strobe_d;
  logic                      phase_q, phase_d;
  logic                      pair_done_q, pair_done_d;
  logic                      busy_q, busy_d;

  logic                      load;
  logic                      last;
  logic [CNT_WIDTH-1:0]      n_clamp, s_clamp, eff_n, eff_s;
  logic [CNT_WIDTH-1:0]      n_nxt, s_nxt;

  spgd_cfg_shadow #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cfg (
    .clk          (clk),
    .rstn         (rstn),
    .load         (load),
    .half_period  (half_period),
    .settle_cycles(settle_cycles),
    .n_clamp      (n_clamp),
    .s_clamp      (s_clamp),
    .eff_n        (eff_n),
    .eff_s        (eff_s)
  );

  assign last = (cnt_q == (eff_n - ONE));
  assign load = enable && ((state_q == IDLE) || ((state_q == LOW) && last));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pair_count_d = pair_count_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = HIGH;
      end
      HIGH: begin
        if (last) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LOW: begin
        if (last) begin
          state_d      = enable ? HIGH : IDLE;
          cnt_d        = '0;
          pair_count_d = pair_count_q + 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they are registered yet
  // aligned with the cycle they describe; on a load edge the fresh clamp applies.
  always_comb begin
    n_nxt       = load ? n_clamp : eff_n;
    s_nxt       = load ? s_clamp : eff_s;
    p_d         = (state_d == HIGH);
    busy_d      = (state_d != IDLE);
    strobe_d    = busy_d && (cnt_d == s_nxt);
    phase_d     = strobe_d && p_d;
    pair_done_d = (state_d == LOW) && (cnt_d == (n_nxt - ONE));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pair_count_q <= '0;
      p_q          <= 1'b0;
      strobe_q     <= 1'b0;
      phase_q      <= 1'b0;
      pair_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pair_count_q <= pair_count_d;
      p_q          <= p_d;
      strobe_q     <= strobe_d;
      phase_q      <= phase_d;
      pair_done_q  <= pair_done_d;
      busy_q       <= busy_d;
    end
  end

  assign P             = p_q;
  assign sample_strobe = strobe_q;
  assign sample_phase  = phase_q;
  assign pair_done     = pair_done_q;
  assign busy          = busy_q;
  assign pair_count    = pair_count_q;

endmodule

// File: tb/tb_spgd_dither_sequencer.sv
// Directed bench for spgd_dither_sequencer; a second instance with a 2-bit
// pair counter shares the stimulus to exercise counter wrap.
module tb_spgd_dither_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [23:0] half_period;
  logic [23:0] settle_cycles;

  logic        P, sample_strobe, sample_phase, pair_done, busy;
  logic [15:0] pair_count;
  logic        P2, strobe2, phase2, pd2, busy2;
  logic [1:0]  pair_count2;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  spgd_dither_sequencer #(.CNT_WIDTH(24), .PAIR_CNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .half_period(half_period), .settle_cycles(settle_cycles),
    .P(P), .sample_strobe(sample_strobe), .sample_phase(sample_phase),
    .pair_done(pair_done), .busy(busy), .pair_count(pair_count)
  );

  spgd_dither_sequencer #(.CNT_WIDTH(24), .PAIR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rstn(rstn), .enable(enable),
    .half_period(half_period), .settle_cycles(settle_cycles),
    .P(P2), .sample_strobe(strobe2), .sample_phase(phase2),
    .pair_done(pd2), .busy(busy2), .pair_count(pair_count2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic ep, input logic es,
                           input logic epd, input logic eb, input logic [15:0] epc);
    chk({tag, ".P"},         32'(P),             32'(ep));
    chk({tag, ".strobe"},    32'(sample_strobe), 32'(es));
    chk({tag, ".phase"},     32'(sample_phase),  32'(es & ep));
    chk({tag, ".pair_done"}, 32'(pair_done),     32'(epd));
    chk({tag, ".busy"},      32'(busy),          32'(eb));
    chk({tag, ".pair_count"},32'(pair_count),    32'(epc));
  endtask

  task automatic chk_zero(input string tag);
    chk_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk({tag, ".dut2_pc"},   32'(pair_count2), 32'd0);
    chk({tag, ".dut2_busy"}, 32'(busy2),       32'd0);
  endtask

  initial begin
    logic [7:0]  pp4;
    logic [7:0]  ss4;
    logic [19:0] pcfg;
    logic [19:0] scfg;
    logic [19:0] dcfg;
    pp4  = 8'b1111_0000;
    ss4  = 8'b0010_0010;
    pcfg = 20'b1111_0000_111111_000000;
    scfg = 20'b0010_0010_001000_001000;
    dcfg = 20'b0000_0001_000000_000001;

    // Reset held with enable high
    rstn = 1'b0; enable = 1'b1; half_period = 24'd4; settle_cycles = 24'd2;
    tick(); tick();
    chk_zero("reset_hold");
    rstn = 1'b1;

    // Basic run N=4, S=2, three pairs
    for (int i = 0; i < 24; i++) begin
      tick();
      chk_cycle($sformatf("basic[%0d]", i), pp4[7 - (i % 8)], ss4[7 - (i % 8)],
                (i % 8) == 7, 1'b1, 16'(i / 8));
    end

    // Enable dropped in 2nd HIGH cycle of 4th pair; pair completes
    tick();
    tick();
    enable = 1'b0;
    chk_cycle("drop[25]", 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    for (int i = 26; i < 32; i++) begin
      tick();
      chk_cycle($sformatf("drop[%0d]", i), pp4[7 - (i % 8)], ss4[7 - (i % 8)],
                (i % 8) == 7, 1'b1, 16'd3);
    end
    tick();
    chk_cycle("drop_idle0", 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
    tick();
    chk_cycle("drop_idle1", 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);

    // Config change mid-pair: 4+4 then 6+6
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_cycle($sformatf("cfg[%0d]", i), pcfg[19 - i], scfg[19 - i], dcfg[19 - i],
                1'b1, (i < 8) ? 16'd4 : 16'd5);
      if (i == 1) half_period = 24'd6;
    end

    rstn = 1'b0;
    #1;
    chk_zero("reset_after_cfg");

    // Async reset in LOW with N=8, counter=3
    half_period = 24'd8; settle_cycles = 24'd3; enable = 1'b1;
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_cycle($sformatf("n8[%0d]", i), i < 8, (i == 3) || (i == 11), 1'b0, 1'b1, 16'd0);
    end
    rstn = 1'b0;
    #1;
    chk_zero("reset_in_low");
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_cycle($sformatf("post_rst[%0d]", i), i < 8, i == 3, 1'b0, 1'b1, 16'd0);
    end

    // Clamping N=1,S=5 -> N=2,S=1; dut2 pair counter wraps
    rstn = 1'b0;
    half_period = 24'd1; settle_cycles = 24'd5;
    #1;
    chk_zero("reset_before_clamp");
    rstn = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick();
      chk_cycle($sformatf("clamp[%0d]", i), (i % 4) < 2, (i % 2) == 1,
                (i % 4) == 3, 1'b1, 16'(i / 4));
      chk($sformatf("wrap_pc[%0d]", i), 32'(pair_count2), 32'((i / 4) % 4));
      chk($sformatf("wrap_P[%0d]", i),  32'(P2),          32'((i % 4) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
